// File: rtl/seg_pkg.sv
// seg_pkg: glyphs, conversion states and control-word bit positions for seg_scan_ctrl
package seg_pkg;
  typedef enum logic [1:0] {IDLE, CONV, DONE} conv_state_e;
  localparam int CTRL_MODE = 0;
  localparam int CTRL_SIGNED = 1;
  localparam int CTRL_LZ = 2;
  localparam int CTRL_EN_LSB = 8;
  localparam logic [7:0] GLYPH_MINUS = 8'hBF;
  localparam logic [7:0] GLYPH_BLANK = 8'hFF;
  localparam logic [7:0] GLYPH_ERR_E = 8'h86;
  localparam logic [7:0] HEX_GLYPH [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };
  function automatic logic [7:0] hex_glyph(input logic [3:0] n);
    return HEX_GLYPH[n];
  endfunction
endpackage

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: CPU IO-bus write port into the display controller
interface seg_scan_ctrl_if;
  logic io_write;
  logic seg_ctrl;
  logic reg_sel;
  logic [31:0] write_data;
  modport master (output io_write, seg_ctrl, reg_sel, write_data);
  modport slave (input io_write, seg_ctrl, reg_sel, write_data);
endinterface

// File: rtl/bcd_dd_conv.sv
// bcd_dd_conv: sequential double-dabble binary-to-BCD converter, one shift step per cycle
module bcd_dd_conv
  import seg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_W-1:0]     data,
  input  logic                  sgn,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg,
  output logic                  ovf
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(DATA_W + 1);
  conv_state_e state;
  logic [DATA_W-1:0] sh;
  logic [CW-1:0] cnt;
  logic [BW-1:0] adj;
  logic is_neg;
  assign is_neg = sgn & data[DATA_W-1];
  assign done = state == DONE;
  always_comb begin
    adj = bcd;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      busy <= 1'b0;
      sh <= '0;
      cnt <= '0;
      bcd <= '0;
      neg <= 1'b0;
      ovf <= 1'b0;
    end else if (start) begin
      state <= CONV;
      busy <= 1'b1;
      sh <= is_neg ? -data : data;
      neg <= is_neg;
      cnt <= '0;
      bcd <= '0;
      ovf <= 1'b0;
    end else if (abort) begin
      state <= IDLE;
      busy <= 1'b0;
    end else if (state == CONV) begin
      // the bit leaving the top digit is the carry into a digit we don't have
      bcd <= {adj[BW-2:0], sh[DATA_W-1]};
      sh <= sh << 1;
      ovf <= ovf | adj[BW-1];
      cnt <= cnt + 1'b1;
      state <= cnt == CW'(DATA_W - 1) ? DONE : CONV;
    end else if (state == DONE) begin
      state <= IDLE;
      busy <= 1'b0;
    end
  end
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: memory-mapped multiplexed 7-segment controller with hex and decimal rendering
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int DATA_W = 32,
  parameter int REFRESH_DIV = 50000
) (
  input  logic              clk,
  input  logic              rstn,
  seg_scan_ctrl_if.slave    bus,
  output logic [DIGITS-1:0] seg_an,
  output logic [7:0]        seg_out,
  output logic              busy
);
  localparam int BW = 4 * DIGITS;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(REFRESH_DIV + 1);
  logic [DATA_W-1:0] value;
  logic mode, sgn, lz;
  logic [DIGITS-1:0] en;
  logic [BW-1:0] dbuf, bcd;
  logic d_neg, d_ovf, c_neg, c_ovf, done;
  logic wr, wr_val, wr_ctl, nxt_mode, nxt_sgn, start, abort;
  logic [DATA_W-1:0] nxt_val;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [IW:0] msd, sign_pos;
  logic err;
  logic [3:0] nib;
  logic [7:0] glyph;
  assign wr = bus.io_write & bus.seg_ctrl;
  assign wr_val = wr & ~bus.reg_sel;
  assign wr_ctl = wr & bus.reg_sel;
  assign nxt_mode = wr_ctl ? bus.write_data[CTRL_MODE] : mode;
  assign nxt_sgn = wr_ctl ? bus.write_data[CTRL_SIGNED] : sgn;
  assign nxt_val = wr_val ? bus.write_data[DATA_W-1:0] : value;
  assign start = wr & nxt_mode;
  assign abort = wr_ctl & ~bus.write_data[CTRL_MODE];
  bcd_dd_conv #(.DATA_W(DATA_W), .DIGITS(DIGITS)) u_conv (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort), .data(nxt_val), .sgn(nxt_sgn),
    .busy(busy), .done(done), .bcd(bcd), .neg(c_neg), .ovf(c_ovf)
  );
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      value <= '0;
      mode <= 1'b0;
      sgn <= 1'b0;
      lz <= 1'b0;
      en <= '1;
      dbuf <= '0;
      d_neg <= 1'b0;
      d_ovf <= 1'b0;
    end else begin
      if (wr_val) value <= bus.write_data[DATA_W-1:0];
      if (wr_ctl) begin
        mode <= bus.write_data[CTRL_MODE];
        sgn <= bus.write_data[CTRL_SIGNED];
        lz <= bus.write_data[CTRL_LZ];
        en <= bus.write_data[CTRL_EN_LSB +: DIGITS];
      end
      // a write landing on DONE restarts or aborts, so the stale result is dropped
      if (!mode) begin
        dbuf <= BW'(value);
        d_neg <= 1'b0;
        d_ovf <= 1'b0;
      end else if (done && !wr) begin
        dbuf <= bcd;
        d_neg <= c_neg;
        d_ovf <= c_ovf;
      end
    end
  end
  always_comb begin
    msd = '0;
    for (int i = 0; i < DIGITS; i++)
      if (dbuf[4*i +: 4] != 4'd0) msd = (IW+1)'(i);
  end
  assign sign_pos = msd + 1'b1;
  assign err = d_ovf | (d_neg & (sign_pos >= (IW+1)'(DIGITS)));
  assign nib = dbuf[4*idx +: 4];
  assign glyph = err ? GLYPH_ERR_E :
                 (d_neg && {1'b0, idx} == sign_pos) ? GLYPH_MINUS :
                 (lz && {1'b0, idx} > msd) ? GLYPH_BLANK : hex_glyph(nib);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
      idx <= '0;
      seg_an <= '1;
      seg_out <= 8'hFF;
    end else begin
      if (cnt == CW'(REFRESH_DIV - 1)) begin
        cnt <= '0;
        idx <= idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      seg_an <= en[idx] ? ~(DIGITS'(1) << idx) : '1;
      seg_out <= glyph;
    end
  end
endmodule
